// File: rtl/gray_to_binary_stream_pkg.sv
// Shared Gray-code helpers and tracker state type for the Gray decoder stream.
// Helpers work on MAX_W-bit words; narrower codes are zero-extended, which leaves results unchanged.
package gray_pkg;

  localparam int MAX_W = 16;

  typedef enum logic {NO_REF, TRACK} tracker_state_e;

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic hamming1(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] d;
    int               cnt;
    d   = a ^ b;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) if (d[i]) cnt++;
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/gray_to_binary_stream_step_checker.sv
// Tracks the previously accepted Gray word and flags non-unit-distance steps,
// keeping a saturating count of those errors.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 accept,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  tracker_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_prev_gray;
  logic [ERR_CNT_W-1:0]  r_err_count;
  logic                  w_step_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= NO_REF;
    else     r_state <= w_state_nxt;
  end

  // A clear coinciding with an accept makes that word the new reference.
  always_comb begin
    w_state_nxt = r_state;
    w_step_err  = 1'b0;
    if (clr) begin
      w_state_nxt = accept ? TRACK : NO_REF;
    end else if (accept) begin
      w_state_nxt = TRACK;
      if (r_state == TRACK)
        w_step_err = !hamming1(MAX_W'(in_gray), MAX_W'(r_prev_gray));
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_prev_gray <= '0;
    else if (accept) r_prev_gray <= in_gray;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_err_count <= '0;
    else if (accept && w_step_err && !(&r_err_count))
      r_err_count <= r_err_count + ERR_CNT_W'(1);
  end

  assign step_err  = w_step_err;
  assign err_count = r_err_count;

endmodule

// File: rtl/gray_to_binary_stream.sv
// Streaming Gray-to-binary decoder with a one-stage registered output,
// valid/ready handshake and unit-distance sequence checking.
module gray_to_binary_stream
  import gray_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_binary,
  output logic                 out_step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_binary;
  logic             r_out_step_err;
  logic             w_accept;
  logic             w_step_err;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  gray_step_checker #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .accept    (w_accept),
    .in_gray   (in_gray),
    .step_err  (w_step_err),
    .err_count (err_count)
  );

  // Output register: loads on accept, drains when the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_binary   <= '0;
      r_out_step_err <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_binary   <= WIDTH'(gray2bin(MAX_W'(in_gray)));
      r_out_step_err <= w_step_err;
    end else if (out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_binary   = r_out_binary;
  assign out_step_err = r_out_step_err;

endmodule

// File: tb/tb_gray_to_binary_stream.sv
// Self-checking bench for gray_to_binary_stream: directed scenarios plus a
// randomized run against a behavioural model.
module tb_gray_to_binary_stream;

  localparam int W  = 3;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, out_ready;
  logic [W-1:0]  in_gray;
  logic          in_ready, out_valid, out_step_err;
  logic [W-1:0]  out_binary;
  logic [EW-1:0] err_count;

  int checks = 0;
  int fails  = 0;

  gray_to_binary_stream #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_gray      (in_gray),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_binary   (out_binary),
    .out_step_err (out_step_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode by searching for the binary value whose Gray code matches.
  function automatic int ref_decode(input int g);
    for (int b = 0; b < (1 << W); b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1; clr = 0; in_valid = 0; out_ready = 1; in_gray = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_binary !== 3'd0) begin fails++; $display("FAIL reset_binary got=%0d exp=0", out_binary); end
    checks++; if (out_step_err !== 1'b0) begin fails++; $display("FAIL reset_step_err got=%0b exp=0", out_step_err); end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    rst = 0;
  endtask

  task automatic test_sequence();
    logic [W-1:0] codes [0:8];
    int           expb  [0:8];
    codes = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    expb  = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_gray = codes[i];
      tick();
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got=%0b exp=1", i, out_valid); end
      checks++; if (out_binary !== W'(expb[i])) begin fails++; $display("FAIL seq_binary[%0d] got=%0d exp=%0d", i, out_binary, expb[i]); end
      checks++; if (out_step_err !== 1'b0) begin fails++; $display("FAIL seq_step_err[%0d] got=%0b exp=0", i, out_step_err); end
    end
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL seq_err_count got=%0d exp=0", err_count); end
    in_valid = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL seq_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    clr = 1; tick(); clr = 0;
    in_valid = 1; in_gray = 3'b000; tick();
    checks++; if (out_step_err !== 1'b0) begin fails++; $display("FAIL ill_first got=%0b exp=0", out_step_err); end
    in_gray = 3'b011; tick();
    checks++; if (out_binary !== 3'd2) begin fails++; $display("FAIL ill_binary got=%0d exp=2", out_binary); end
    checks++; if (out_step_err !== 1'b1) begin fails++; $display("FAIL ill_step got=%0b exp=1", out_step_err); end
    checks++; if (err_count !== 2'd1) begin fails++; $display("FAIL ill_cnt1 got=%0d exp=1", err_count); end
    tick();
    checks++; if (out_step_err !== 1'b1) begin fails++; $display("FAIL ill_repeat got=%0b exp=1", out_step_err); end
    checks++; if (err_count !== 2'd2) begin fails++; $display("FAIL ill_cnt2 got=%0d exp=2", err_count); end
    in_valid = 0;
  endtask

  task automatic test_backpressure();
    clr = 1; tick(); clr = 0;
    out_ready = 1; in_valid = 1; in_gray = 3'b110; tick();
    checks++; if (out_binary !== 3'd4) begin fails++; $display("FAIL bp_first got=%0d exp=4", out_binary); end
    out_ready = 0; in_gray = 3'b111; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      tick();
      checks++; if (out_binary !== 3'd4 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d] got=%0d/%0b exp=4/1", i, out_binary, out_valid); end
    end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    tick();
    checks++; if (out_binary !== 3'd5 || out_step_err !== 1'b0) begin fails++; $display("FAIL bp_after got=%0d/%0b exp=5/0", out_binary, out_step_err); end
    in_valid = 0;
  endtask

  task automatic test_clear_saturation();
    int expc [0:4];
    expc = '{1, 2, 3, 3, 3};
    clr = 1; tick(); clr = 0;
    out_ready = 1; in_valid = 1; in_gray = 3'b000; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (err_count !== EW'(expc[i]) || out_step_err !== 1'b1) begin fails++; $display("FAIL sat[%0d] got=%0d/%0b exp=%0d/1", i, err_count, out_step_err, expc[i]); end
    end
    clr = 1; in_gray = 3'b010; tick(); clr = 0;
    checks++; if (err_count !== 2'd0) begin fails++; $display("FAIL clr_cnt got=%0d exp=0", err_count); end
    checks++; if (out_step_err !== 1'b0 || out_binary !== 3'd3) begin fails++; $display("FAIL clr_word got=%0b/%0d exp=0/3", out_step_err, out_binary); end
    in_gray = 3'b000; tick();
    checks++; if (out_step_err !== 1'b0 || out_binary !== 3'd0) begin fails++; $display("FAIL clr_next got=%0b/%0d exp=0/0", out_step_err, out_binary); end
    in_valid = 0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1; in_valid = 1; in_gray = 3'b000; tick();
    checks++; if (err_count !== 2'd1) begin fails++; $display("FAIL rm_pre_cnt got=%0d exp=1", err_count); end
    in_valid = 0; out_ready = 0; tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rm_stall got=%0b exp=1", out_valid); end
    rst = 1; tick(); rst = 0;
    checks++; if (out_valid !== 1'b0 || out_binary !== 3'd0 || err_count !== 2'd0) begin fails++; $display("FAIL rm_reset got=%0b/%0d/%0d exp=0/0/0", out_valid, out_binary, err_count); end
    out_ready = 1; in_valid = 1; in_gray = 3'b111; tick();
    checks++; if (out_step_err !== 1'b0 || out_binary !== 3'd5) begin fails++; $display("FAIL rm_first got=%0b/%0d exp=0/5", out_step_err, out_binary); end
    in_valid = 0;
  endtask

  task automatic test_random();
    bit m_valid, m_err, m_have, acc, e;
    int m_bin, m_cnt, m_prev, g;
    rst = 1; clr = 0; in_valid = 0; out_ready = 1; tick(); rst = 0;
    m_valid = 0; m_err = 0; m_have = 0; m_bin = 0; m_cnt = 0; m_prev = 0;
    for (int n = 0; n < 400; n++) begin
      if (m_have && ($urandom % 4 != 0)) g = m_prev ^ (1 << ($urandom % W));
      else                               g = $urandom % (1 << W);
      in_gray   = W'(g);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr       = ($urandom % 16) == 0;
      rst       = ($urandom % 64) == 0;
      #1;
      checks++; if (in_ready !== (!m_valid || out_ready)) begin fails++; $display("FAIL rnd_in_ready[%0d] got=%0b exp=%0b", n, in_ready, !m_valid || out_ready); end
      acc = in_valid && (!m_valid || out_ready);
      if (rst) begin
        m_valid = 0; m_bin = 0; m_err = 0; m_cnt = 0; m_have = 0; m_prev = 0;
      end else begin
        e = acc && m_have && !clr && ($countones(g ^ m_prev) != 1);
        if (acc) begin
          m_valid = 1; m_bin = ref_decode(g); m_err = e; m_prev = g;
        end else if (out_ready) begin
          m_valid = 0;
        end
        if (clr)                m_cnt = 0;
        else if (e && m_cnt < 3) m_cnt++;
        m_have = clr ? acc : (m_have || acc);
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== m_valid) begin fails++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", n, out_valid, m_valid); end
      checks++; if (out_binary !== W'(m_bin) || out_step_err !== m_err) begin fails++; $display("FAIL rnd_data[%0d] got=%0d/%0b exp=%0d/%0b", n, out_binary, out_step_err, m_bin, m_err); end
      checks++; if (err_count !== EW'(m_cnt)) begin fails++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, err_count, m_cnt); end
    end
    rst = 0; clr = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_illegal();
    test_backpressure();
    test_clear_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
